// File: rtl/tetris_pkg.sv
// Shared op codes, FSM states, score table and LFSR helpers for the falling-piece game sequencer.
package tetris_pkg;

   typedef enum logic [2:0] {
      OP_NONE    = 3'd0,
      OP_LEFT    = 3'd1,
      OP_RIGHT   = 3'd2,
      OP_DOWN    = 3'd3,
      OP_ROTATE  = 3'd4,
      OP_GRAVITY = 3'd5,
      OP_SPAWN   = 3'd6
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SPAWN,
      ST_PLAY,
      ST_CHECK,
      ST_COMMIT,
      ST_LOCK,
      ST_CLEAR,
      ST_GAMEOVER
   } state_e;

   // Pending-key bit positions, in service priority order.
   localparam int KEY_UP    = 0;
   localparam int KEY_LEFT  = 1;
   localparam int KEY_RIGHT = 2;
   localparam int KEY_DOWN  = 3;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Taps 16,14,13,11 expressed as a mask over bits 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsrNext(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic [3:0] shapeFromLfsr(input logic [15:0] s);
      return (s[3:0] == 4'hF) ? 4'h0 : s[3:0];
   endfunction

   function automatic logic [3:0] scorePoints(input logic [2:0] rows);
      case (rows)
         3'd1:    return 4'd1;
         3'd2:    return 4'd3;
         3'd3:    return 4'd5;
         3'd4:    return 4'd8;
         default: return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/tetris_fall_timer.sv
// Level-dependent gravity counter; raises a sticky tick request each elapsed period.
module tetris_fall_timer
   import tetris_pkg::*;
#(
   parameter int unsigned TICK_BASE = 3500000,
   parameter int unsigned TICK_STEP = 300000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       run_i,
   input  logic       restart_i,
   input  logic       tick_clr_i,
   input  logic [3:0] level_i,
   output logic       tick_pend_o
);

   logic [31:0] cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic [31:0] period;
   logic        wrap;

   assign period = 32'(TICK_BASE) - (32'(level_i) - 32'd1) * 32'(TICK_STEP);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
      end
   end

   // A tick landing on an already-pending flag simply merges into it.
   always_comb begin
      wrap   = run_i && (cnt_q >= period - 32'd1);
      cnt_d  = cnt_q;
      pend_d = (pend_q & ~tick_clr_i) | wrap;
      if (restart_i) begin
         cnt_d  = '0;
         pend_d = 1'b0;
      end else if (run_i) begin
         cnt_d = wrap ? 32'd0 : cnt_q + 32'd1;
      end
   end

   assign tick_pend_o = pend_q;

endmodule

// File: rtl/tetris_game_ctrl.sv
// Piece life-cycle sequencer: arbitrates gravity and key moves through one collision checker,
// then handles lock, line clear, scoring, levels and game over.
module tetris_game_ctrl
   import tetris_pkg::*;
#(
   parameter int unsigned TICK_BASE = 3500000,
   parameter int unsigned TICK_STEP = 300000,
   parameter int unsigned MAX_LEVEL = 10
) (
   input  logic        iVGA_CLK,
   input  logic        iRST_N,
   input  logic        start,
   input  logic        key_up,
   input  logic        key_left,
   input  logic        key_right,
   input  logic        key_down,
   output logic        chk_req,
   output logic [2:0]  chk_op,
   input  logic        chk_ack,
   input  logic        chk_hit,
   output logic        move_en,
   output logic [2:0]  move_op,
   output logic [3:0]  shape_sel,
   output logic        lock_req,
   input  logic        lock_ack,
   output logic        clear_req,
   input  logic        clear_ack,
   input  logic [2:0]  clear_cnt,
   output logic [3:0]  level,
   output logic [15:0] score,
   output logic        game_over
);

   state_e      state_q, state_d;
   op_e         op_q, op_d, chk_op_q, chk_op_d, move_op_q, move_op_d;
   logic [3:0]  pend_q, pend_d, key_prev_q, keys, key_edge, pend_svc;
   logic [15:0] lfsr_q;
   logic [3:0]  shape_q, shape_d, level_q, level_d, lines_q, lines_d;
   logic [15:0] score_q, score_d;
   logic        chk_req_q, chk_req_d, move_en_q, move_en_d;
   logic        lock_req_q, lock_req_d, clear_req_q, clear_req_d;
   logic        game_over_q, game_over_d;
   logic        tick_pend, tick_clr, timer_restart, timer_run, capture, pend_flush;
   logic        chk_done, lock_done, clear_done;
   logic [7:0]  gain;
   logic [16:0] score_sum;
   logic [4:0]  lines_sum;

   assign keys      = {key_down, key_right, key_left, key_up};
   assign key_edge  = key_prev_q & ~keys;
   assign timer_run = (state_q == ST_PLAY) || (state_q == ST_CHECK) || (state_q == ST_COMMIT);
   assign capture   = timer_run;

   tetris_fall_timer #(
      .TICK_BASE (TICK_BASE),
      .TICK_STEP (TICK_STEP)
   ) u_fall_timer (
      .clk_i       (iVGA_CLK),
      .rst_ni      (iRST_N),
      .run_i       (timer_run),
      .restart_i   (timer_restart),
      .tick_clr_i  (tick_clr),
      .level_i     (level_q),
      .tick_pend_o (tick_pend)
   );

   always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_NONE;
         chk_op_q    <= OP_NONE;
         move_op_q   <= OP_NONE;
         pend_q      <= '0;
         key_prev_q  <= '1;
         lfsr_q      <= LFSR_SEED;
         shape_q     <= '0;
         level_q     <= 4'd1;
         lines_q     <= '0;
         score_q     <= '0;
         chk_req_q   <= 1'b0;
         move_en_q   <= 1'b0;
         lock_req_q  <= 1'b0;
         clear_req_q <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         chk_op_q    <= chk_op_d;
         move_op_q   <= move_op_d;
         pend_q      <= pend_d;
         key_prev_q  <= keys;
         lfsr_q      <= lfsrNext(lfsr_q);
         shape_q     <= shape_d;
         level_q     <= level_d;
         lines_q     <= lines_d;
         score_q     <= score_d;
         chk_req_q   <= chk_req_d;
         move_en_q   <= move_en_d;
         lock_req_q  <= lock_req_d;
         clear_req_q <= clear_req_d;
         game_over_q <= game_over_d;
      end
   end

   // Acks only count while the matching request is actually being driven.
   assign chk_done   = chk_req_q & chk_ack;
   assign lock_done  = lock_req_q & lock_ack;
   assign clear_done = clear_req_q & clear_ack;
   assign gain       = 8'(scorePoints(clear_cnt)) * 8'(level_q);
   assign score_sum  = 17'(score_q) + 17'(gain);
   assign lines_sum  = 5'(lines_q) + 5'(clear_cnt);

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      shape_d       = shape_q;
      level_d       = level_q;
      lines_d       = lines_q;
      score_d       = score_q;
      move_en_d     = 1'b0;
      move_op_d     = move_op_q;
      tick_clr      = 1'b0;
      timer_restart = 1'b0;
      pend_flush    = 1'b0;
      pend_svc      = '0;

      case (state_q)
         ST_IDLE, ST_GAMEOVER: begin
            if (start) begin
               state_d = ST_SPAWN;
               score_d = '0;
               level_d = 4'd1;
               lines_d = '0;
            end
         end
         ST_SPAWN: begin
            shape_d       = shapeFromLfsr(lfsr_q);
            timer_restart = 1'b1;
            pend_flush    = 1'b1;
            op_d          = OP_SPAWN;
            state_d       = ST_CHECK;
         end
         ST_PLAY: begin
            if (tick_pend) begin
               op_d    = OP_GRAVITY;
               state_d = ST_CHECK;
            end else if (pend_q[KEY_UP]) begin
               op_d    = OP_ROTATE;
               state_d = ST_CHECK;
            end else if (pend_q[KEY_LEFT]) begin
               op_d    = OP_LEFT;
               state_d = ST_CHECK;
            end else if (pend_q[KEY_RIGHT]) begin
               op_d    = OP_RIGHT;
               state_d = ST_CHECK;
            end else if (pend_q[KEY_DOWN]) begin
               op_d    = OP_DOWN;
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (chk_done) begin
               case (op_q)
                  OP_GRAVITY: tick_clr            = 1'b1;
                  OP_ROTATE:  pend_svc[KEY_UP]    = 1'b1;
                  OP_LEFT:    pend_svc[KEY_LEFT]  = 1'b1;
                  OP_RIGHT:   pend_svc[KEY_RIGHT] = 1'b1;
                  OP_DOWN:    pend_svc[KEY_DOWN]  = 1'b1;
                  default:    ;
               endcase
               if (!chk_hit)
                  state_d = ST_COMMIT;
               else if (op_q == OP_SPAWN)
                  state_d = ST_GAMEOVER;
               else if (op_q == OP_GRAVITY || op_q == OP_DOWN)
                  state_d = ST_LOCK;
               else
                  state_d = ST_PLAY;
            end
         end
         ST_COMMIT: begin
            move_en_d = 1'b1;
            move_op_d = op_q;
            state_d   = ST_PLAY;
         end
         ST_LOCK: begin
            if (lock_done)
               state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (clear_done) begin
               score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
               if (lines_sum >= 5'd10) begin
                  lines_d = 4'(lines_sum - 5'd10);
                  if (level_q < 4'(MAX_LEVEL))
                     level_d = level_q + 4'd1;
               end else begin
                  lines_d = lines_sum[3:0];
               end
               state_d = ST_SPAWN;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      pend_d      = pend_flush ? 4'b0000 : ((pend_q & ~pend_svc) | (capture ? key_edge : 4'b0000));
      chk_req_d   = (state_q == ST_CHECK) && !chk_done;
      chk_op_d    = (state_q == ST_CHECK) ? op_q : chk_op_q;
      lock_req_d  = (state_q == ST_LOCK) && !lock_done;
      clear_req_d = (state_q == ST_CLEAR) && !clear_done;
      game_over_d = (state_d == ST_GAMEOVER);
   end

   assign chk_req   = chk_req_q;
   assign chk_op    = chk_op_q;
   assign move_en   = move_en_q;
   assign move_op   = move_op_q;
   assign shape_sel = shape_q;
   assign lock_req  = lock_req_q;
   assign clear_req = clear_req_q;
   assign level     = level_q;
   assign score     = score_q;
   assign game_over = game_over_q;

endmodule
